// File: rtl/operand_fifo.sv
// rtl/operand_fifo.sv - operand-pair FIFO with first-word-fall-through outputs
//
// Purpose: buffers (multiplicand, multiplier) pairs between a producer and a
// multiplier controller. The head pair is presented combinationally so the
// controller can sample it in the same cycle it pulses load_words.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous active-low reset
//   push_valid        producer offers a pair this cycle
//   push_ready        FIFO can accept a pair (!full)
//   push_multiplicand multiplicand of the offered pair
//   push_multiplier   multiplier of the offered pair
//   load_words        pop request; consumes the head pair
//   multiplicand_out  head multiplicand, 0 while empty
//   multiplier_out    head multiplier, 0 while empty
//   empty             no valid entries
//   full              DEPTH valid entries held
//   count             number of valid entries, 0..DEPTH
//   underflow_err     sticky: pop attempted while empty
//   overflow_err      sticky: push attempted while full

module operand_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [WIDTH-1:0]         push_multiplicand,
    input  logic [WIDTH-1:0]         push_multiplier,
    input  logic                     load_words,
    output logic [WIDTH-1:0]         multiplicand_out,
    output logic [WIDTH-1:0]         multiplier_out,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow_err,
    output logic                     overflow_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mcand_mem [DEPTH];
    logic [WIDTH-1:0] mplier_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          underflow_q, underflow_d;
    logic          overflow_q, overflow_d;

    logic empty_w;
    logic full_w;
    logic push_acc;
    logic pop_acc;

    // Flags come only from the registered count, never from the inputs.
    assign empty_w  = (count_q == '0);
    assign full_w   = (count_q == DEPTH_C);

    assign push_acc = push_valid && !full_w;
    assign pop_acc  = load_words && !empty_w;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q || (load_words && empty_w);
        overflow_d  = overflow_q  || (push_valid && full_w);

        // Pointers are exactly AW bits wide, so +1 wraps DEPTH-1 -> 0.
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    // Storage is not reset; stale words are never visible because the
    // outputs are forced to zero whenever count is zero.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mcand_mem[wr_ptr_q]  <= push_multiplicand;
            mplier_mem[wr_ptr_q] <= push_multiplier;
        end
    end

    assign multiplicand_out = empty_w ? '0 : mcand_mem[rd_ptr_q];
    assign multiplier_out   = empty_w ? '0 : mplier_mem[rd_ptr_q];

    assign empty         = empty_w;
    assign full          = full_w;
    assign push_ready    = !full_w;
    assign count         = count_q;
    assign underflow_err = underflow_q;
    assign overflow_err  = overflow_q;

endmodule

// File: doc/operand_fifo.md
OPERAND_FIFO -- requirements
Module: operand_fifo

Interface
REQ-001 Parameter WIDTH, default 16, bit width of each operand word.
REQ-002 Parameter DEPTH, default 4, number of operand-pair entries; SHALL be a power of two >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 push_valid  input  1  producer offers an operand pair this cycle.
REQ-006 push_ready  output  1  FIFO can accept a pair; equals !full.
REQ-007 push_multiplicand  input  WIDTH  multiplicand of the offered pair.
REQ-008 push_multiplier  input  WIDTH  multiplier of the offered pair.
REQ-009 load_words  input  1  pop request from the multiplier controller; consumes the head pair.
REQ-010 multiplicand_out  output  WIDTH  head-entry multiplicand (first-word-fall-through).
REQ-011 multiplier_out  output  WIDTH  head-entry multiplier (first-word-fall-through).
REQ-012 empty  output  1  no valid entries; drives the controller's empty input.
REQ-013 full  output  1  DEPTH valid entries held.
REQ-014 count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-015 underflow_err  output  1  sticky flag: pop attempted while empty.
REQ-016 overflow_err  output  1  sticky flag: push attempted while full.

Function
REQ-017 Storage SHALL be a circular buffer of DEPTH pairs with write and read pointers of $clog2(DEPTH) bits, each wrapping from DEPTH-1 to 0.
REQ-018 A push SHALL be accepted in a cycle iff push_valid=1 and full=0, both sampled before the clock edge.
REQ-019 An accepted push SHALL write both words at the write pointer and advance the pointer by one.
REQ-020 A pop SHALL be accepted in a cycle iff load_words=1 and empty=0, both sampled before the clock edge.
REQ-021 An accepted pop SHALL advance the read pointer by one.
REQ-022 multiplicand_out/multiplier_out SHALL combinationally present the entry at the read pointer, so data is valid in the same cycle load_words is asserted.
REQ-023 While empty=1, multiplicand_out/multiplier_out SHALL read as 0.
REQ-024 An accepted push and an accepted pop in the same cycle SHALL leave count unchanged; both pointers advance.
REQ-025 Push with pop while full: pop accepted, push rejected (push_ready=0), overflow_err set; count becomes DEPTH-1.
REQ-026 Push with pop while empty: push accepted, pop rejected, underflow_err set; count becomes 1; the pushed pair is visible at the outputs in the next cycle.
REQ-027 count SHALL be registered and SHALL change by +1, -1 or 0 per cycle only.
REQ-028 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH), both derived from registered state with no combinational path from inputs.
REQ-029 underflow_err and overflow_err SHALL remain set until reset once asserted.
REQ-030 Rejected pushes and pops SHALL leave storage, pointers and count unchanged.
REQ-031 Latency from accepted push into an empty FIFO to empty=0 SHALL be one clock edge.

Reset
REQ-032 On reset=0, independent of clk: pointers=0, count=0, empty=1, full=0, push_ready=1, data outputs=0, both error flags=0.
REQ-033 Storage contents need not be cleared; no stale entry SHALL ever be presented after reset.
REQ-034 Reset asserted mid-operation SHALL discard all held entries immediately; the first edge after release with push_valid=1 SHALL accept a push.

Verification
REQ-035 Reset, then push (3,5): next cycle empty=0, count=1, multiplicand_out=3, multiplier_out=5; pulse load_words -> empty=1, count=0.
REQ-036 DEPTH=4: push (1,1),(2,2),(3,3),(4,4) -> full=1, push_ready=0; fifth push (9,9) -> rejected, overflow_err=1, count=4; four pops return 1,2,3,4 in order.
REQ-037 Wrap-around: 6 push/pop alternations then fill to 4 -> outputs pop in FIFO order across the pointer wrap, with no lost or duplicated pair.
REQ-038 Simultaneous push+pop at count=2 -> count stays 2, head advances; at count=4 -> count=3, overflow_err=1; at count=0 -> count=1, underflow_err=1.
REQ-039 load_words=1 while empty after reset -> underflow_err=1, count=0, outputs 0; flag persists until reset.
REQ-040 Reset asserted asynchronously with count=3 -> empty=1, count=0, errors cleared before the next clk edge.
